snes_serial_responder: RTL and testbench
========================================

# snes_serial_responder

Controller-side end of the SNES serial port: it presents the 12-bit merged button word to a SNES console, which acts as the initiator. The console drives LATCH and CLOCK asynchronously; this block synchronizes both and shifts the latched buttons out on DATA, active-low, in the standard 16-bit frame order. It sits after the PS/2, IR and button-board decoders and the source-select logic, and drives the controller-port DATA pin.

## Interface

- `TURBO_FRAMES`, default 4: number of completed frames per turbo phase. Used only when `SNES_TURBO_EN` is defined; legal range 1..255.
- `clk` input 1: system clock, 2.08 MHz on-chip oscillator.
- `reset_n` input 1: one clock; reset is synchronous and active-low.
- `buttons` input 12: 1 = pressed. Bit mapping [0]=B, [1]=Y, [2]=Select, [3]=Start, [4]=Up, [5]=Down, [6]=Left, [7]=Right, [8]=A, [9]=X, [10]=L, [11]=R.
- `snes_latch` input 1: console LATCH, asynchronous, active-high.
- `snes_clock` input 1: console CLOCK, asynchronous, idle high.
- `snes_data` output 1: controller DATA. 0 = pressed, registered.
- `frame_done` output 1: one-cycle pulse when the 16th bit completes.
- `bit_index` output 5: index of the bit currently on `snes_data`, 0..16.

## Operation

- **Synchronizers.** Both `snes_latch` and `snes_clock` pass through 2-FF synchronizers. A third stage is used for edge detection.
- **Shadow register.** The shadow register `shadow[15:0]` holds `{4'b0000, buttons}`. Bits 12..15 are always reported as "not pressed" (DATA = 1).
- **State machine.**
  - **IDLE.** `snes_data`=1 and `bit_index`=0.
    - Synced latch rise: capture `shadow`, go to LATCH.
  - **LATCH.** `snes_data` = ~`shadow[0]` and `bit_index`=0.
    - Clock edges are ignored.
    - Synced latch fall: go to SHIFT.
  - **SHIFT.**
    - Each synced clock rising edge increments `bit_index` and drives `snes_data` = ~`shadow[bit_index]`.
    - The rising edge that takes `bit_index` to 16 goes to DONE and pulses `frame_done`.
  - **DONE.** `snes_data`=0, `bit_index` is held at 16.
    - Synced latch rise: capture `shadow`, go to LATCH.
- **Latch rise in any state** (including mid-SHIFT) aborts the current frame, recaptures `shadow`, and enters LATCH. No `frame_done` is issued for the aborted frame.
- **Simultaneous latch rise and clock rise** in the same cycle: the latch wins and the clock edge is discarded.
- **Clock falling edges** are ignored in all states.
- **Clock rising edges in IDLE or DONE** are ignored.
- **`buttons`** is sampled only on the capture cycle. Changes during a frame do not affect that frame.
- **Reset.** While `reset_n`=0 at a `clk` edge:
  - state = IDLE;
  - `snes_data`=1, `bit_index`=0, `frame_done`=0;
  - `shadow`=0;
  - synchronizer flops = 0 for latch and 1 for clock;
  - turbo counter = 0 and phase = 0.

  Reset mid-frame abandons the frame without a `frame_done` pulse.

## Timing

- **Latency.** From a pin edge to the `snes_data` update is 3–4 `clk` cycles: 2 synchronizer stages + 1 edge detect + 1 output register.
- **Throughput requirement.** At 2.08 MHz (481 ns period), the console's 6 µs CLOCK half-period gives at least 12 cycles per phase. Every edge must be detected.
  - DATA is stable at least 8 `clk` cycles before the console samples it.
- **Minimum pulse widths.** LATCH and CLOCK pulses shorter than 2 `clk` cycles may be missed. This is acceptable; no glitch filtering is performed.
- **`frame_done`** is asserted for exactly one cycle, in the same cycle that `snes_data` becomes 0 in DONE.

## Configuration

- **`SNES_TURBO_EN` defined:**
  - An 8-bit counter increments on each `frame_done`.
  - On reaching `TURBO_FRAMES`, it clears and toggles `turbo_phase`.
  - When `turbo_phase`=1, the captured A (bit 8) and B (bit 0) are forced to 0 (released) in `shadow` at capture time.
  - Other buttons are unaffected.
- **`SNES_TURBO_EN` undefined:**
  - No counter or phase logic exists, and `shadow` captures `buttons` unmodified.
  - `TURBO_FRAMES` is unused.

## Test plan

- **Basic frame.** `buttons`=12'h101 (B, A). Drive a 12 µs latch, then 16 clock pulses of 6 µs low / 6 µs high.
  - Sampled DATA sequence (bit 0 first) = 0,1,1,1,1,1,1,1,0,1,1,1,1,1,1,1.
  - `frame_done` pulses once, then DATA=0.
- **Capture isolation.** `buttons`=12'h000 at latch. Change to 12'hFFF during the shift.
  - All 16 bits read 1.
- **Mid-frame abort.** Issue a new latch after 5 clock pulses, with `buttons`=12'h010 (Up).
  - No `frame_done` is issued.
  - The new frame reads bit 4 = 0 and all other bits = 1.
- **Reset mid-frame.** Assert `reset_n`=0 for one cycle after 8 clocks.
  - `snes_data`=1 and `bit_index`=0.
  - Subsequent clock pulses leave the state in IDLE until the next latch.
- **Race and idle edges.**
  - Latch rise and clock rise in the same synced cycle: result is `bit_index`=0 and state LATCH.
  - 3 clock pulses while in IDLE: `snes_data` stays 1.
- **Turbo** (`SNES_TURBO_EN`, `TURBO_FRAMES`=2). Hold `buttons`=12'h103 (B, Y, A) over 8 frames.
  - B and A read pressed in frames 1–2, released in 3–4, pressed in 5–6, and released in 7–8.
  - Y reads pressed in all frames.

Source files
------------

// File: rtl/snes_serial_responder.sv
// snes_serial_responder: controller-side SNES serial port.
// Synchronizes the console's LATCH and CLOCK and shifts a captured 16-bit
// button frame out on DATA (active-low, bit 0 first).
// Optional feature macro: SNES_TURBO_EN (turbo auto-release of A and B).
module snes_serial_responder #(
  parameter int unsigned TURBO_FRAMES = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [11:0] buttons,
  input  logic        snes_latch,
  input  logic        snes_clock,
  output logic        snes_data,
  output logic        frame_done,
  output logic [4:0]  bit_index
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LATCH = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  // A turbo period outside 1..255 cannot be represented by the 8-bit counter.
  if (TURBO_FRAMES < 1 || TURBO_FRAMES > 255) begin : g_bad_turbo_frames
    $error("TURBO_FRAMES must be in 1..255");
  end

  state_t      state;
  state_t      state_n;
  logic [15:0] shadow;
  logic [15:0] shadow_n;
  logic [15:0] capture;
  logic        data_n;
  logic        done_n;
  logic [4:0]  idx_n;
  logic [4:0]  idx_inc;

  // Synchronizer chains; the third stage only feeds edge detection.
  logic        latch_s1, latch_s2, latch_s3;
  logic        clock_s1, clock_s2, clock_s3;
  logic        latch_rise, latch_fall, clock_rise;

  // Two-stage synchronizers plus one history stage for each console pin.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      latch_s1 <= 1'b0;
      latch_s2 <= 1'b0;
      latch_s3 <= 1'b0;
      clock_s1 <= 1'b1;
      clock_s2 <= 1'b1;
      clock_s3 <= 1'b1;
    end else begin
      latch_s1 <= snes_latch;
      latch_s2 <= latch_s1;
      latch_s3 <= latch_s2;
      clock_s1 <= snes_clock;
      clock_s2 <= clock_s1;
      clock_s3 <= clock_s2;
    end
  end

  assign latch_rise = latch_s2 & ~latch_s3;
  assign latch_fall = ~latch_s2 & latch_s3;
  assign clock_rise = clock_s2 & ~clock_s3;

`ifdef SNES_TURBO_EN
  localparam logic [7:0] TURBO_LIMIT = 8'(TURBO_FRAMES);

  logic [7:0] turbo_cnt;
  logic       turbo_phase;

  // Count completed frames; flip the turbo phase every TURBO_FRAMES frames.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      turbo_cnt   <= 8'd0;
      turbo_phase <= 1'b0;
    end else if (done_n) begin
      if (turbo_cnt + 8'd1 == TURBO_LIMIT) begin
        turbo_cnt   <= 8'd0;
        turbo_phase <= ~turbo_phase;
      end else begin
        turbo_cnt <= turbo_cnt + 8'd1;
      end
    end
  end

  // Captured frame word; A and B read released during the turbo-off phase.
  always_comb begin
    capture = {4'b0000, buttons};
    if (turbo_phase) begin
      capture[8] = 1'b0;
      capture[0] = 1'b0;
    end
  end
`else
  // Captured frame word: the four unused trailing bits always read released.
  always_comb begin
    capture = {4'b0000, buttons};
  end
`endif

  // State, shadow and registered port outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      shadow     <= 16'h0000;
      snes_data  <= 1'b1;
      bit_index  <= 5'd0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      shadow     <= shadow_n;
      snes_data  <= data_n;
      bit_index  <= idx_n;
      frame_done <= done_n;
    end
  end

  // Next-state and next-output logic; a latch rise overrides everything,
  // including a coincident clock rise.
  always_comb begin
    state_n  = state;
    shadow_n = shadow;
    data_n   = snes_data;
    idx_n    = bit_index;
    done_n   = 1'b0;
    idx_inc  = bit_index + 5'd1;
    if (latch_rise) begin
      state_n  = LATCH;
      shadow_n = capture;
      data_n   = ~capture[0];
      idx_n    = 5'd0;
    end else begin
      case (state)
        IDLE: begin
          data_n = 1'b1;
          idx_n  = 5'd0;
        end
        LATCH: begin
          if (latch_fall) begin
            state_n = SHIFT;
          end
        end
        SHIFT: begin
          if (clock_rise) begin
            idx_n = idx_inc;
            if (idx_inc == 5'd16) begin
              state_n = DONE;
              data_n  = 1'b0;
              done_n  = 1'b1;
            end else begin
              data_n = ~shadow[idx_inc[3:0]];
            end
          end
        end
        DONE: begin
          data_n = 1'b0;
          idx_n  = 5'd16;
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_snes_serial_responder.sv
// Directed testbench for snes_serial_responder.
// Console-side timing: 12 us latch, 6 us low / 6 us high clock pulses.
`timescale 1ns/1ps
module tb_snes_serial_responder;

  logic        clk;
  logic        reset_n;
  logic [11:0] buttons;
  logic        snes_latch;
  logic        snes_clock;
  logic        snes_data;
  logic        frame_done;
  logic [4:0]  bit_index;

  int checks;
  int passes;
  int fd_count;

  snes_serial_responder #(.TURBO_FRAMES(2)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .buttons    (buttons),
    .snes_latch (snes_latch),
    .snes_clock (snes_clock),
    .snes_data  (snes_data),
    .frame_done (frame_done),
    .bit_index  (bit_index)
  );

  // ~2.08 MHz system clock
  initial clk = 1'b0;
  always #240 clk = ~clk;

  // Count frame_done pulses, sampled mid-cycle.
  always @(negedge clk) begin
    if (frame_done === 1'b1) fd_count++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) begin
      passes++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse_latch();
    snes_latch = 1'b1;
    #12000;
    snes_latch = 1'b0;
    #6000;
  endtask

  // One clock pulse; returns DATA as seen just before the rising edge.
  task automatic clock_pulse(output logic d);
    snes_clock = 1'b0;
    #5500;
    @(negedge clk);
    d = snes_data;
    snes_clock = 1'b1;
    #6000;
  endtask

  task automatic shift_frame(output logic [15:0] bits);
    logic d;
    for (int i = 0; i < 16; i++) begin
      clock_pulse(d);
      bits[i] = d;
    end
  endtask

  logic [15:0] bits;
  logic        d;

  initial begin
    checks     = 0;
    passes     = 0;
    fd_count   = 0;
    reset_n    = 1'b0;
    buttons    = 12'h000;
    snes_latch = 1'b0;
    snes_clock = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Reset state
    check("rst_data", 32'(snes_data), 32'd1);
    check("rst_index", 32'(bit_index), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);

    // Basic frame: B and A pressed
    buttons  = 12'h101;
    fd_count = 0;
    pulse_latch();
    check("basic_latch_index", 32'(bit_index), 32'd0);
    check("basic_latch_data", 32'(snes_data), 32'd0);
    shift_frame(bits);
    check("basic_bits", 32'(bits), 32'h0000FEFE);
    check("basic_done_count", 32'(fd_count), 32'd1);
    check("basic_done_data", 32'(snes_data), 32'd0);
    check("basic_done_index", 32'(bit_index), 32'd16);

    // Capture isolation: buttons change after capture
    buttons  = 12'h000;
    fd_count = 0;
    pulse_latch();
    buttons = 12'hFFF;
    shift_frame(bits);
    check("iso_bits", 32'(bits), 32'h0000FFFF);
    check("iso_done_count", 32'(fd_count), 32'd1);

    // Mid-frame abort after 5 pulses
    buttons  = 12'h0F0;
    fd_count = 0;
    pulse_latch();
    for (int i = 0; i < 5; i++) clock_pulse(d);
    check("abort_mid_index", 32'(bit_index), 32'd5);
    buttons = 12'h010;
    pulse_latch();
    check("abort_no_done", 32'(fd_count), 32'd0);
    check("abort_relatch_index", 32'(bit_index), 32'd0);
    shift_frame(bits);
    check("abort_bits", 32'(bits), 32'h0000FFEF);
    check("abort_done_count", 32'(fd_count), 32'd1);

    // Reset mid-frame after 8 pulses
    buttons  = 12'h0FF;
    fd_count = 0;
    pulse_latch();
    for (int i = 0; i < 8; i++) clock_pulse(d);
    check("rstmid_index_before", 32'(bit_index), 32'd8);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rstmid_data", 32'(snes_data), 32'd1);
    check("rstmid_index", 32'(bit_index), 32'd0);
    // Idle clock pulses are ignored
    for (int i = 0; i < 3; i++) begin
      clock_pulse(d);
      check("idle_pulse_data", 32'(snes_data), 32'd1);
    end
    check("idle_index", 32'(bit_index), 32'd0);
    check("rstmid_no_done", 32'(fd_count), 32'd0);

    // Latch and clock rising together mid-frame: latch wins
    buttons = 12'h001;
    pulse_latch();
    for (int i = 0; i < 3; i++) clock_pulse(d);
    check("race_pre_index", 32'(bit_index), 32'd3);
    snes_clock = 1'b0;
    #6000;
    snes_latch = 1'b1;
    snes_clock = 1'b1;
    #6000;
    check("race_index", 32'(bit_index), 32'd0);
    check("race_data", 32'(snes_data), 32'd0);
    snes_latch = 1'b0;
    #6000;
    fd_count = 0;
    shift_frame(bits);
    check("race_bits", 32'(bits), 32'h0000FFFE);
    check("race_done_count", 32'(fd_count), 32'd1);

`ifdef SNES_TURBO_EN
    // Turbo with TURBO_FRAMES=2: A/B alternate every two frames
    do_reset();
    buttons = 12'h103;
    for (int f = 1; f <= 8; f++) begin
      pulse_latch();
      shift_frame(bits);
      if (((f - 1) / 2) % 2 == 0) check($sformatf("turbo_frame%0d", f), 32'(bits), 32'h0000FEFC);
      else                        check($sformatf("turbo_frame%0d", f), 32'(bits), 32'h0000FFFD);
    end
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
